// File: rtl/serial_logic_unit_32.sv
// rtl/serial_logic_unit_32.sv - bit-serial 32-bit logic unit (AND/OR/NOR/NOT/BUF)
//
// Purpose:
//   Low-area logic path beside the ALU. A, B and OPR are latched on a START
//   handshake. The unit then evaluates DIGIT result bits per clock and
//   returns a registered WIDTH-bit result together with DONE and ZERO flags.
//   The FSM walks IDLE -> RUN (N = WIDTH/DIGIT cycles) -> FIN -> IDLE.
//   Y, ZERO, ERR and DONE are all registered on the edge that leaves FIN.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   synchronous active-high reset, has priority over everything
//   START  in   request, sampled only while READY
//   OPR    in   [2:0] 000 AND, 001 OR, 010 NOR, 011 NOT A, 100 BUF A, others illegal
//   A, B   in   [WIDTH-1:0] operands, captured with START (B unused by NOT/BUF)
//   READY  out  high in IDLE
//   BUSY   out  high in RUN
//   DONE   out  one-cycle pulse in the cycle that Y was just updated
//   Y      out  [WIDTH-1:0] result register, held until the next completion
//   ZERO   out  registered (Y == 0)
//   ERR    out  registered, set when the completed operation had an illegal opcode

module serial_logic_unit_32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OPR,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO,
  output logic             ERR
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] res_digit;
  logic             illegal;

  // Opcodes 101..111 are illegal.
  assign illegal = op_r[2] & (op_r[1] | op_r[0]);

  // Per-digit operation on the LSBs of the shifting operand copies.
  // Illegal opcodes yield zero digits, so the result ends up all zeros.
  always_comb begin
    res_digit = '0;
    case (op_r)
      3'b000:  res_digit = a_sh[DIGIT-1:0] & b_sh[DIGIT-1:0];
      3'b001:  res_digit = a_sh[DIGIT-1:0] | b_sh[DIGIT-1:0];
      3'b010:  res_digit = ~(a_sh[DIGIT-1:0] | b_sh[DIGIT-1:0]);
      3'b011:  res_digit = ~a_sh[DIGIT-1:0];
      3'b100:  res_digit = a_sh[DIGIT-1:0];
      default: res_digit = '0;
    endcase
  end

  // The new digit enters at the MSB end. After N shifts the first digit
  // has reached bit 0, which puts every result bit in its own position.
  // The shift form also stays legal when DIGIT == WIDTH.
  assign acc_next = (acc >> DIGIT) | (WIDTH'(res_digit) << (WIDTH - DIGIT));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and status decode. Outputs come only from registered
  // state, so there is no combinational path from START.
  always_comb begin
    state_d = state_q;
    READY   = 1'b0;
    BUSY    = 1'b0;
    case (state_q)
      IDLE: begin
        READY = 1'b1;
        if (START) begin
          state_d = RUN;
        end
      end
      RUN: begin
        BUSY = 1'b1;
        if (cnt == LAST) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: capture, serial evaluation and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_sh <= '0;
      b_sh <= '0;
      op_r <= '0;
      acc  <= '0;
      cnt  <= '0;
      Y    <= '0;
      ZERO <= 1'b1;
      ERR  <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            a_sh <= A;
            b_sh <= B;
            op_r <= OPR;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= acc_next;
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          cnt  <= cnt + CW'(1);
        end
        FIN: begin
          // The outputs load on the edge that leaves FIN. DONE is therefore
          // high in the same cycle that the new Y becomes visible.
          Y    <= acc;
          ZERO <= (acc == '0);
          ERR  <= illegal;
          DONE <= 1'b1;
        end
        default: begin
          DONE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_logic_unit_32.md
Name: serial_logic_unit_32

Overview:
Multi-cycle, bit-serial counterpart of the 32-bit parallel gate library (AND/OR/NOR/NOT/BUF). It latches two operands and an opcode on a START handshake and evaluates DIGIT bits per clock. It returns a registered 32-bit result with DONE and ZERO flags. It sits beside the ALU as a low-area logic path for the virtual CPU, driven by the control unit.

Parameters:
WIDTH, 32, operand/result width in bits
DIGIT, 1, bits processed per cycle; must divide WIDTH (legal: 1, 2, 4, 8, 16, 32)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset; synchronous and active-high
START  input  1  request; sampled only when READY=1
OPR  input  3  opcode: 000 AND, 001 OR, 010 NOR, 011 NOT A, 100 BUF A, 101-111 illegal
A  input  WIDTH  operand A; captured with START
B  input  WIDTH  operand B; captured with START, ignored for NOT/BUF
READY  output  1  high in IDLE; unit accepts START
BUSY  output  1  high in RUN
DONE  output  1  one-cycle pulse when Y has been updated
Y  output  WIDTH  result register; holds its value until the next completion
ZERO  output  1  registered (Y==0), updated together with Y
ERR  output  1  registered; set at completion if OPR was illegal

Behaviour:
- States: IDLE, RUN, FIN. Digit count N = WIDTH/DIGIT.
- Reset (RST=1 at a rising edge): state=IDLE, Y=0, ZERO=1, ERR=0, DONE=0. All internal shift registers and the counter are cleared. Reset has priority over every other input.
- READY = (state==IDLE); BUSY = (state==RUN). Both are decoded from registered state, so no combinational path from START exists.
- IDLE: on START=1, capture A, B and OPR into internal registers, clear the counter and go to RUN. START=0 stays in IDLE.
- RUN, each cycle:
  - apply the op to the DIGIT LSBs of the captured A/B;
  - shift the result digit into the MSB end of the accumulator (right shift by DIGIT);
  - shift the A/B copies right by DIGIT;
  - increment the counter.
  After the Nth RUN cycle, go to FIN.
- FIN: load Y from the accumulator, ZERO=(accumulator==0), ERR=illegal opcode. Assert DONE for this single cycle, then return to IDLE.
- Illegal opcode: the result digits are 0, so Y=0, ZERO=1, ERR=1. ERR clears at the next legal completion.
- Latency: with START sampled at edge k, DONE is high during the cycle following edge k+N+1. Y, ZERO and ERR are valid in that same cycle. Next START is accepted at edge k+N+2. Throughput is one op per N+2 cycles.
- START while BUSY or in FIN: ignored, no queuing, captured operands undisturbed.
- Input changes after capture have no effect on the result.
- Reset mid-RUN: the operation is aborted, no DONE is produced, and Y is forced to 0.
- Y, ZERO and ERR never change outside FIN or reset.

Test Plan:
- Reset, then idle 5 cycles -> READY=1, BUSY=0, DONE=0, Y=0x00000000, ZERO=1, ERR=0.
- DIGIT=1, A=0xF0F000FF, B=0x0FF00F0F, OPR=000 -> DONE exactly 33 edges after the START edge, Y=0x00F0000F, ZERO=0. Repeat OPR=001 -> Y=0xFFF00FFF.
- DIGIT=4, same operands: OPR=010 -> Y=0x000FF000 with DONE 9 edges after START; OPR=011 -> Y=0x0F0FFF00; OPR=100 -> Y=0xF0F000FF.
- Back-to-back: hold START=1 continuously with A and B changing every cycle. Only the first operands are used (AND result 0x00F0000F), and the next op starts at edge k+N+2. A=0, B=0 AND -> ZERO=1.
- OPR=110, A=0xFFFFFFFF -> Y=0, ZERO=1, ERR=1. Follow with a legal op (OPR=000, A=0xFFFFFFFF, B=0x00000001) -> ERR=0, Y=0x00000001.
- After a completed op gives Y=0x00F0000F, assert RST at RUN cycle 10 of the next op -> no DONE pulse, Y=0, state IDLE next cycle. A new START completes normally.
